// File: rtl/spi_rx_sampled.sv
// spi_rx_sampled -- oversampled SPI slave receiver with a word FIFO.
//
// All three SPI pins are brought into the clk domain through SYNC_STAGES
// flops, so the receiver is plain synchronous logic. Words of WIDTH bits
// are assembled for any CPOL/CPHA combination and either bit order, then
// queued in a DEPTH-entry FIFO behind a valid/ready stream.
//
// Optional build macro: SPI_RX_PARTIAL_EN -- a frame that ends mid-word
// pushes the partial word (unfilled positions zero) and flags it on
// rx_partial. Without it partial words are dropped and rx_partial is 0.
//
// Ports:
//   clk, rst          system clock (>= 4x spi_sck), synchronous active-high reset
//   spi_sck/csn/sdi   asynchronous SPI pins (csn active low)
//   rx_data           FIFO head word, zero while empty
//   rx_valid          FIFO not empty
//   rx_ready          consumer pops the head when rx_valid & rx_ready
//   rx_level          FIFO occupancy, 0..DEPTH
//   rx_overflow       pulse: a word was dropped because the FIFO was full
//   frame_active      receiver is inside an accepted frame
//   frame_end         pulse on the synchronized rising edge of csn
//   rx_partial        head word is a partial word
module spi_rx_sampled #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_sck,
  input  logic                     spi_csn,
  input  logic                     spi_sdi,
  output logic [WIDTH-1:0]         rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic                     rx_overflow,
  output logic                     frame_active,
  output logic                     frame_end,
  output logic                     rx_partial
);

  localparam int   LP_AW   = $clog2(DEPTH);
  localparam int   LP_CW   = $clog2(WIDTH);
  localparam logic LP_CPOL = (CPOL != 0);
  localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(WIDTH - 1);
`ifdef SPI_RX_PARTIAL_EN
  localparam int   LP_FW   = WIDTH + 1;
`else
  localparam int   LP_FW   = WIDTH;
`endif

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_csn_sync, r_sdi_sync, r_prime;
  logic                   r_sck_d, r_csn_seen;
  state_t                 r_state, w_state_nxt;
  logic [LP_CW-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_shreg, w_shreg_in;
  logic [LP_FW-1:0]       r_mem [DEPTH];
  logic [LP_FW-1:0]       w_push_data, w_head;
  logic [LP_AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [LP_AW:0]         r_level;
  logic w_sck, w_csn, w_sdi, w_lead, w_trail, w_sample;
  logic w_shift_en, w_word_done, w_frame_end, w_push_req, w_push, w_pop;
  logic w_full, w_empty;

  // Synchronizers plus the delayed sck copy used for edge detection.
  // r_prime fills with ones after reset; its top bit marks the point where
  // the last synchronizer stage holds a real pin sample instead of the
  // reset-loaded value, so a frame already running at reset is not taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_sync <= {SYNC_STAGES{LP_CPOL}};
      r_csn_sync <= '1;
      r_sdi_sync <= '0;
      r_prime    <= '0;
      r_sck_d    <= LP_CPOL;
      r_csn_seen <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_csn_sync <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      r_prime    <= {r_prime[SYNC_STAGES-2:0], 1'b1};
      r_sck_d    <= w_sck;
      if (w_csn && r_prime[SYNC_STAGES-1]) r_csn_seen <= 1'b1;
    end
  end

  assign w_sck    = r_sck_sync[SYNC_STAGES-1];
  assign w_csn    = r_csn_sync[SYNC_STAGES-1];
  assign w_sdi    = r_sdi_sync[SYNC_STAGES-1];
  assign w_lead   = (r_sck_d == LP_CPOL) && (w_sck != LP_CPOL);
  assign w_trail  = (r_sck_d != LP_CPOL) && (w_sck == LP_CPOL);
  assign w_sample = (CPHA != 0) ? w_trail : w_lead;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!w_csn && r_csn_seen) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_csn) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign frame_active = (r_state == ST_SHIFT);
  assign w_frame_end  = (r_state == ST_SHIFT) && w_csn;
  assign frame_end    = w_frame_end;
  // A sample edge coinciding with csn rising is ignored.
  assign w_shift_en   = (r_state == ST_SHIFT) && !w_csn && w_sample;
  assign w_word_done  = w_shift_en && (r_cnt == LP_LAST);
  assign w_shreg_in   = (LSB_FIRST != 0) ? {w_sdi, r_shreg[WIDTH-1:1]}
                                         : {r_shreg[WIDTH-2:0], w_sdi};

  always_ff @(posedge clk) begin
    if (rst || w_frame_end) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (w_shift_en) begin
      if (w_word_done) begin
        r_cnt   <= '0;
        r_shreg <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
        r_shreg <= w_shreg_in;
      end
    end
  end

`ifdef SPI_RX_PARTIAL_EN
  // Received bits sit at the "recent" end of the shift register; moving
  // them to the word's first-bit end leaves the unfilled positions zero.
  logic [WIDTH-1:0] w_part_word;
  always_comb begin
    w_part_word = '0;
    if (LSB_FIRST != 0) w_part_word = r_shreg >> (WIDTH - int'(r_cnt));
    else                w_part_word = r_shreg << (WIDTH - int'(r_cnt));
  end
`endif

  always_comb begin
    w_push_req  = 1'b0;
    w_push_data = '0;
    if (w_word_done) begin
      w_push_req  = 1'b1;
      w_push_data = LP_FW'(w_shreg_in);
    end
`ifdef SPI_RX_PARTIAL_EN
    else if (w_frame_end && (r_cnt != '0)) begin
      w_push_req  = 1'b1;
      w_push_data = {1'b1, w_part_word};
    end
`endif
  end

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == (LP_AW+1)'(DEPTH));
  assign w_pop       = rx_ready && !w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign rx_overflow = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign rx_data  = w_empty ? '0 : w_head[WIDTH-1:0];
  assign rx_valid = !w_empty;
  assign rx_level = r_level;
`ifdef SPI_RX_PARTIAL_EN
  assign rx_partial = w_empty ? 1'b0 : w_head[WIDTH];
`else
  assign rx_partial = 1'b0;
`endif

endmodule
